// File: rtl/calc_pkg.sv
// Shared state codes and add/sub select values for the calculator front-end.
package calc_pkg;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_EXEC = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

endpackage

// File: rtl/button_debounce.sv
// Button conditioning: 2-flop synchroniser, counting debouncer, rising-edge pulse.
module button_debounce #(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic ev
);

    localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_q <= level;
            // Any cycle agreeing with the filtered level restarts the stability count.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign ev = level & ~level_q;

endmodule

// File: rtl/calc_sequencer.sv
// ENTER/CLEAR driven sequencer producing load strobes and add/sub select for the calculator datapath.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_enter,
    input  logic       btn_clear,
    input  logic       op_sw,
    output logic       ld_a,
    output logic       ld_b,
    output logic       ld_out,
    output logic       op_sel,
    output logic [1:0] phase
);

    state_t state;
    logic   enter_ev;
    logic   clear_ev;

    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_enter (
        .clk (clk),
        .rst (rst),
        .btn (btn_enter),
        .ev  (enter_ev)
    );

    button_debounce #(.DB_CYCLES(DB_CYCLES)) u_clear (
        .clk (clk),
        .rst (rst),
        .btn (btn_clear),
        .ev  (clear_ev)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_A;
            ld_a   <= 1'b0;
            ld_b   <= 1'b0;
            ld_out <= 1'b0;
            op_sel <= OP_ADD;
        end else begin
            ld_a   <= 1'b0;
            ld_b   <= 1'b0;
            ld_out <= 1'b0;
            // Clear overrides everything, including a coincident enter and the EXEC step.
            if (clear_ev) begin
                state <= S_A;
            end else begin
                unique case (state)
                    S_A: if (enter_ev) begin
                        state <= S_B;
                        ld_a  <= 1'b1;
                    end
                    S_B: if (enter_ev) begin
                        state  <= S_EXEC;
                        ld_b   <= 1'b1;
                        op_sel <= op_sw;
                    end
                    S_EXEC: begin
                        state  <= S_SHOW;
                        ld_out <= 1'b1;
                    end
                    S_SHOW: if (enter_ev) begin
                        state <= S_A;
                    end
                    default: state <= S_A;
                endcase
            end
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer with a small Reg_A/Reg_B/Reg_out + adder harness.
module tb_calc_sequencer;

    localparam int unsigned DB = 4;
    localparam logic [1:0] K_A   = 2'd1;
    localparam logic [1:0] K_B   = 2'd2;
    localparam logic [1:0] K_OUT = 2'd3;

    logic       clk;
    logic       rst;
    logic       btn_enter;
    logic       btn_clear;
    logic       op_sw;
    logic       ld_a;
    logic       ld_b;
    logic       ld_out;
    logic       op_sel;
    logic [1:0] phase;

    logic [3:0] sw_a;
    logic [3:0] sw_b;
    logic [3:0] reg_a;
    logic [3:0] reg_b;
    logic [3:0] reg_out;

    typedef struct {
        logic [1:0] kind;
        logic       op;
    } exp_t;

    exp_t exp_q[$];
    int   tests;
    int   fails;

    calc_sequencer #(.DB_CYCLES(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_enter (btn_enter),
        .btn_clear (btn_clear),
        .op_sw     (op_sw),
        .ld_a      (ld_a),
        .ld_b      (ld_b),
        .ld_out    (ld_out),
        .op_sel    (op_sel),
        .phase     (phase)
    );

    // Datapath harness: registers are not reset so rst cannot disturb a stored result.
    always_ff @(posedge clk) begin
        if (ld_a)   reg_a   <= sw_a;
        if (ld_b)   reg_b   <= sw_b;
        if (ld_out) reg_out <= op_sel ? (reg_a + reg_b) : (reg_a - reg_b);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: samples just after each active edge and retires one expectation per strobe.
    initial begin
        logic prev_b;
        int   n;
        exp_t e;
        prev_b = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            n = int'(ld_a) + int'(ld_b) + int'(ld_out);
            if (n > 1) check("strobe_onehot", n, 1);
            if (n > 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", n, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind", ld_a ? 1 : ld_b ? 2 : 3, int'(e.kind));
                    if (ld_out) check("op_sel_at_ld_out", int'(op_sel), int'(e.op));
                end
            end
            if (prev_b && !rst) check("ld_out_after_ld_b", int'(ld_out), 1);
            if (ld_out)         check("ld_b_before_ld_out", int'(prev_b), 1);
            prev_b = ld_b;
        end
    end

    task automatic push(input logic [1:0] kind, input logic op);
        exp_t e;
        e.kind = kind;
        e.op   = op;
        exp_q.push_back(e);
    endtask

    task automatic press_enter(input int hold);
        btn_enter = 1'b1;
        repeat (hold) @(negedge clk);
        btn_enter = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic press_clear();
        btn_clear = 1'b1;
        repeat (10) @(negedge clk);
        btn_clear = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic drained(input string name);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int guard;
        tests = 0;
        fails = 0;
        rst = 1'b1;
        btn_enter = 1'b1;
        btn_clear = 1'b1;
        op_sw = 1'b0;
        sw_a = 4'd0;
        sw_b = 4'd0;

        // 1: reset with buttons held
        repeat (3) @(negedge clk);
        check("rst_ld_a", int'(ld_a), 0);
        check("rst_ld_b", int'(ld_b), 0);
        check("rst_ld_out", int'(ld_out), 0);
        check("rst_phase", int'(phase), 0);
        check("rst_op_sel", int'(op_sel), 1);
        rst = 1'b0;
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (6) @(negedge clk);
        check("post_rst_phase", int'(phase), 0);

        // 2: 5 + 3
        sw_a = 4'd5;
        push(K_A, 1'b0);
        press_enter(10);
        check("t2_phase_b", int'(phase), 1);
        sw_b = 4'd3;
        op_sw = 1'b1;
        push(K_B, 1'b0);
        push(K_OUT, 1'b1);
        press_enter(10);
        check("t2_phase", int'(phase), 3);
        check("t2_op_sel", int'(op_sel), 1);
        check("t2_reg_out", int'(reg_out), 8);
        drained("t2_drained");

        // 3: 3 - 7 wraps to 0xC
        press_enter(10);
        check("t3_back_to_a", int'(phase), 0);
        sw_a = 4'd3;
        push(K_A, 1'b0);
        press_enter(10);
        sw_b = 4'd7;
        op_sw = 1'b0;
        push(K_B, 1'b0);
        push(K_OUT, 1'b0);
        press_enter(10);
        check("t3_reg_out", int'(reg_out), 12);
        check("t3_op_sel", int'(op_sel), 0);
        op_sw = 1'b1;
        repeat (5) @(negedge clk);
        op_sw = 1'b0;
        repeat (2) @(negedge clk);
        op_sw = 1'b1;
        repeat (5) @(negedge clk);
        check("t3_op_sel_held", int'(op_sel), 0);
        check("t3_phase", int'(phase), 3);
        drained("t3_drained");

        // 4: glitch, long hold, bounce
        press_enter(10);
        check("t4_phase_a", int'(phase), 0);
        press_enter(3);
        check("t4_glitch_phase", int'(phase), 0);
        push(K_A, 1'b0);
        press_enter(100);
        check("t4_hold_phase", int'(phase), 1);
        press_clear();
        check("t4_clear_phase", int'(phase), 0);
        btn_enter = 1'b1;
        repeat (2) @(negedge clk);
        btn_enter = 1'b0;
        @(negedge clk);
        push(K_A, 1'b0);
        press_enter(10);
        check("t4_bounce_phase", int'(phase), 1);
        drained("t4_drained");

        // 5: coincident clear + enter in S_B, then clear in S_SHOW
        btn_enter = 1'b1;
        btn_clear = 1'b1;
        repeat (10) @(negedge clk);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (12) @(negedge clk);
        check("t5_coincide_phase", int'(phase), 0);
        sw_a = 4'd9;
        push(K_A, 1'b0);
        press_enter(10);
        sw_b = 4'd4;
        op_sw = 1'b1;
        push(K_B, 1'b0);
        push(K_OUT, 1'b1);
        press_enter(10);
        check("t5_reg_out", int'(reg_out), 13);
        check("t5_show_phase", int'(phase), 3);
        press_clear();
        check("t5_clear_phase", int'(phase), 0);
        drained("t5_drained");

        // 6: reset during the EXEC cycle
        sw_a = 4'd1;
        push(K_A, 1'b0);
        press_enter(10);
        sw_b = 4'd1;
        op_sw = 1'b0;
        push(K_B, 1'b0);
        btn_enter = 1'b1;
        guard = 0;
        while (!ld_b && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) check("t6_ld_b_timeout", guard, 0);
        rst = 1'b1;
        btn_enter = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("t6_phase", int'(phase), 0);
        check("t6_op_sel", int'(op_sel), 1);
        check("t6_reg_out", int'(reg_out), 13);
        drained("t6_drained");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
